// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads on a split addr/data bus,
// buffers one word for decode. Optional misaligned-fetch trap enabled by FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        ERR
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_f, pc_f_n;
    logic [31:0] target;
    logic        pend, pend_n;
    logic        issue;
    logic        capture;
    logic        drop;
    logic        bad;
    logic        err_held;
    logic        redir_any;

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;
    assign target    = redirect_pc;
    assign err_held  = err_q;
    assign fetch_err = err_q;
`else
    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign err_held  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // A redirect seen while the request was still waiting for its address handshake
    assign redir_any = redirect | pend;

    always_comb begin
        state_n = state;
        pc_f_n  = pc_f;
        pend_n  = pend;
        issue   = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        bad     = 1'b0;
        case (state)
            IDLE: begin
                state_n = REQ;
                issue   = 1'b1;
            end
            REQ: begin
                if (redirect) pc_f_n = target;
                if (ireq_addr_ok) begin
                    pend_n = 1'b0;
                    if (iresp_data_ok) begin
                        if (redir_any) begin
                            state_n = REQ;
                            issue   = 1'b1;
                        end else begin
                            capture = 1'b1;
                            pc_f_n  = pc_f + 32'd4;
                            state_n = HOLD;
                        end
                    end else begin
                        state_n = redir_any ? DRAIN : WAIT;
                    end
                end else if (redirect) begin
                    pend_n = 1'b1;
                end
            end
            WAIT: begin
                if (iresp_data_ok) begin
                    if (redirect) begin
                        pc_f_n  = target;
                        state_n = REQ;
                        issue   = 1'b1;
                    end else begin
                        capture = 1'b1;
                        pc_f_n  = pc_f + 32'd4;
                        state_n = HOLD;
                    end
                end else if (redirect) begin
                    pc_f_n  = target;
                    state_n = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_f_n  = target;
                    drop    = 1'b1;
                    state_n = REQ;
                    issue   = 1'b1;
                end else if (instr_ready) begin
                    drop = 1'b1;
                    if (err_held) begin
                        state_n = ERR;
                    end else begin
                        state_n = REQ;
                        issue   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (redirect) pc_f_n = target;
                if (iresp_data_ok) begin
                    state_n = REQ;
                    issue   = 1'b1;
                end
            end
            ERR: begin
                if (redirect) begin
                    pc_f_n  = target;
                    state_n = REQ;
                    issue   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        // A misaligned target never reaches the bus; a nop carrying the bad PC is presented instead
        if (issue && (pc_f_n[1:0] != 2'b00)) begin
            issue   = 1'b0;
            bad     = 1'b1;
            pend_n  = 1'b0;
            state_n = HOLD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_f        <= RESET_PC;
            pend        <= 1'b0;
            ireq_valid  <= 1'b0;
            ireq_addr   <= 32'd0;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            pc          <= 32'd0;
        end else begin
            state <= state_n;
            pc_f  <= pc_f_n;
            pend  <= pend_n;
            // The request register is only loaded on issue, so it holds steady until accepted
            if (issue) begin
                ireq_valid <= 1'b1;
                ireq_addr  <= pc_f_n;
            end else if (ireq_valid && ireq_addr_ok) begin
                ireq_valid <= 1'b0;
            end
            if (capture) begin
                instr       <= iresp_data;
                pc          <= pc_f;
                instr_valid <= 1'b1;
            end else if (bad) begin
                instr       <= 32'd0;
                pc          <= pc_f_n;
                instr_valid <= 1'b1;
            end else if (drop) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bad) begin
            err_q <= 1'b1;
        end else if (issue) begin
            err_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// sequential-PC scoreboard with a latency-randomized memory responder.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    int          p_addr = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    int          hold_addr = 0;
    int          cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] req_log[$];

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Advance one clock, then play the memory: accept addresses and return data in order
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = $urandom;
        if (reset) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (ireq_valid) begin
                if (hold_addr > 0) begin
                    hold_addr--;
                end else if (int'($urandom_range(99)) < p_addr) begin
                    ireq_addr_ok = 1'b1;
                    q_addr.push_back(ireq_addr);
                    q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                    req_log.push_back(ireq_addr);
                end
            end
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                iresp_data_ok = 1'b1;
                iresp_data    = memf(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
        p_addr = 100; lat_min = 0; lat_max = 0; hold_addr = 0;
        step();
        step();
        reset = 1'b0;
        req_log.delete();
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = instr_valid;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            ok = instr_valid;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234_5678;
        repeat (3) step();
        redirect = 1'b0;
        checks++; if (ireq_valid !== 1'b0) begin failures++; $display("FAIL reset_ireq_valid got=%b exp=0", ireq_valid); end
        checks++; if (ireq_addr !== 32'd0) begin failures++; $display("FAIL reset_ireq_addr got=%h exp=0", ireq_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
        reset = 1'b0; instr_ready = 1'b0;
        step();
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
            failures++; $display("FAIL first_request got=%b/%h exp=1/%h", ireq_valid, ireq_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] got_pc[$];
        logic [31:0] got_ins[$];
        int          got_cyc[$];
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (instr_valid && instr_ready) begin
                got_pc.push_back(pc); got_ins.push_back(instr); got_cyc.push_back(i);
            end
            step();
        end
        checks++;
        if (got_pc.size() < 3 || req_log.size() < 3) begin
            failures++; $display("FAIL seq_count got=%0d/%0d exp>=3", got_pc.size(), req_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (req_log[k] !== RST_PC + 32'(4 * k)) begin
                    failures++; $display("FAIL seq_req_addr%0d got=%h exp=%h", k, req_log[k], RST_PC + 32'(4 * k));
                end
                checks++;
                if (got_pc[k] !== RST_PC + 32'(4 * k) || got_ins[k] !== memf(RST_PC + 32'(4 * k))) begin
                    failures++; $display("FAIL seq_word%0d got=%h/%h exp=%h/%h", k, got_pc[k], got_ins[k],
                                         RST_PC + 32'(4 * k), memf(RST_PC + 32'(4 * k)));
                end
            end
            checks++;
            if (got_cyc[0] != 2) begin failures++; $display("FAIL seq_latency got=%0d exp=2", got_cyc[0]); end
            checks++;
            if (got_cyc[1] - got_cyc[0] != 2) begin
                failures++; $display("FAIL seq_throughput got=%0d exp=2", got_cyc[1] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_addr_stall();
        bit ok;
        do_reset();
        hold_addr = 3;
        instr_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
                failures++; $display("FAIL stall_req_stable%0d got=%b/%h exp=1/%h", i, ireq_valid, ireq_addr, RST_PC);
            end
            step();
        end
        wait_valid(10, ok);
        checks++;
        if (!ok || pc !== RST_PC || instr !== memf(RST_PC)) begin
            failures++; $display("FAIL stall_data got=%b/%h/%h exp=1/%h/%h", ok, pc, instr, RST_PC, memf(RST_PC));
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        do_reset();
        lat_min = 2; lat_max = 2;
        instr_ready = 1'b1;
        step();
        step();
        checks++;
        if (ireq_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rw_in_wait got=%b/%b exp=0/0", ireq_valid, instr_valid);
        end
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        lat_min = 0; lat_max = 0;
        step();
        redirect = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== 32'h8000_0100 || instr !== memf(32'h8000_0100)) begin
            failures++; $display("FAIL rw_first_word got=%b/%h/%h exp=1/80000100/%h", ok, pc, instr, memf(32'h8000_0100));
        end
        checks++;
        if (req_log.size() < 2 || req_log[1] !== 32'h8000_0100) begin
            failures++; $display("FAIL rw_next_req got_n=%0d got=%h exp=80000100", req_log.size(),
                                 (req_log.size() > 1) ? req_log[1] : 32'd0);
        end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        do_reset();
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== RST_PC) begin failures++; $display("FAIL rh_held got=%b/%h exp=1/%h", ok, pc, RST_PC); end
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0200;
        step();
        redirect = 1'b0; instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_0200) begin
            failures++; $display("FAIL rh_next_cycle got=%b/%b/%h exp=0/1/80000200", instr_valid, ireq_valid, ireq_addr);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== 32'h8000_0200 || instr !== memf(32'h8000_0200)) begin
            failures++; $display("FAIL rh_target_word got=%b/%h/%h exp=1/80000200/%h", ok, pc, instr, memf(32'h8000_0200));
        end
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", ok, pc); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== 32'd0 || instr !== memf(32'd0)) begin
            failures++; $display("FAIL wrap_zero got=%b/%h/%h exp=1/0/%h", ok, pc, instr, memf(32'd0));
        end
    endtask

    task automatic test_ready_stall();
        bit          ok;
        logic [31:0] p0, i0;
        int          n0;
        do_reset();
        wait_valid(20, ok);
        p0 = pc; i0 = instr; n0 = req_log.size();
        checks++;
        if (!ok || p0 !== RST_PC) begin failures++; $display("FAIL rs_first got=%b/%h exp=1/%h", ok, p0, RST_PC); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || pc !== p0 || instr !== i0 || ireq_valid !== 1'b0 || req_log.size() != n0) begin
                failures++; $display("FAIL rs_stable%0d got=%b/%h/%h/%b exp=1/%h/%h/0", i, instr_valid, pc, instr, ireq_valid, p0, i0);
            end
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== p0 + 32'd4) begin
            failures++; $display("FAIL rs_release got=%b/%b/%h exp=0/1/%h", instr_valid, ireq_valid, ireq_addr, p0 + 32'd4);
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        do_reset();
        wait_valid(20, ok);
        redirect = 1'b1; redirect_pc = 32'h8000_0102;
        step();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        begin
            int n0;
            n0 = req_log.size();
            checks++;
            if (instr_valid !== 1'b1 || fetch_err !== 1'b1 || pc !== 32'h8000_0102 || instr !== 32'd0 || ireq_valid !== 1'b0) begin
                failures++; $display("FAIL mis_trap got=%b/%b/%h/%h/%b exp=1/1/80000102/0/0", instr_valid, fetch_err, pc, instr, ireq_valid);
            end
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            checks++;
            if (instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
                failures++; $display("FAIL mis_after_consume got=%b/%b exp=0/1", instr_valid, fetch_err);
            end
            repeat (4) step();
            checks++;
            if (ireq_valid !== 1'b0 || req_log.size() != n0 || instr_valid !== 1'b0) begin
                failures++; $display("FAIL mis_idle got=%b/%0d/%b exp=0/%0d/0", ireq_valid, req_log.size(), instr_valid, n0);
            end
            redirect = 1'b1; redirect_pc = 32'h8000_0300;
            step();
            redirect = 1'b0;
            checks++;
            if (fetch_err !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_0300) begin
                failures++; $display("FAIL mis_recover got=%b/%b/%h exp=0/1/80000300", fetch_err, ireq_valid, ireq_addr);
            end
        end
`else
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_0100 || fetch_err !== 1'b0) begin
            failures++; $display("FAIL mis_masked got=%b/%h/%b exp=1/80000100/0", ireq_valid, ireq_addr, fetch_err);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== 32'h8000_0100) begin failures++; $display("FAIL mis_masked_word got=%b/%h exp=1/80000100", ok, pc); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        lat_min = 5; lat_max = 5;
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (ireq_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rm_reset got=%b/%b exp=0/0", ireq_valid, instr_valid);
        end
        reset = 1'b0; lat_min = 0; lat_max = 0;
        step();
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
            failures++; $display("FAIL rm_restart got=%b/%h exp=1/%h", ireq_valid, ireq_addr, RST_PC);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== RST_PC || instr !== memf(RST_PC)) begin
            failures++; $display("FAIL rm_word got=%b/%h/%h exp=1/%h/%h", ok, pc, instr, RST_PC, memf(RST_PC));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr, prev_pc;
        logic        stall_prev, keep_prev;
        int          ncons;
        do_reset();
        p_addr = 70; lat_min = 0; lat_max = 3;
        exp_pc = RST_PC; ncons = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(99) < 60);
            redirect    = (c > 3) && ($urandom_range(99) < 5);
            redirect_pc = 32'h8000_0000 | ($urandom_range(1023) << 2);
            if (ireq_valid && ireq_addr[1:0] != 2'b00) begin
                checks++; failures++; $display("FAIL rnd_align got=%h", ireq_addr);
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (pc !== exp_pc || instr !== memf(exp_pc)) begin
                    failures++; $display("FAIL rnd_word c=%0d got=%h/%h exp=%h/%h", c, pc, instr, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (redirect) exp_pc = redirect_pc;
            stall_prev = ireq_valid && !ireq_addr_ok;
            prev_addr  = ireq_addr;
            keep_prev  = instr_valid && !instr_ready && !redirect;
            prev_pc    = pc;
            step();
            if (stall_prev) begin
                checks++;
                if (ireq_valid !== 1'b1 || ireq_addr !== prev_addr) begin
                    failures++; $display("FAIL rnd_req_hold c=%0d got=%b/%h exp=1/%h", c, ireq_valid, ireq_addr, prev_addr);
                end
            end
            if (keep_prev) begin
                checks++;
                if (instr_valid !== 1'b1 || pc !== prev_pc) begin
                    failures++; $display("FAIL rnd_buf_hold c=%0d got=%b/%h exp=1/%h", c, instr_valid, pc, prev_pc);
                end
            end
        end
        redirect = 1'b0; instr_ready = 1'b0;
        checks++;
        if (ncons < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", ncons); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_addr_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_ready_stall();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
